// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS execution-trace monitor.
// Holds the capture FSM states and the count-width helper.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } trace_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mips_trace_ram.sv
// Trace storage: simple dual-port RAM, synchronous write,
// registered read (cleared by reset so rd outputs start at 0).
module mips_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mips_trace_monitor.sv
// Execution-trace capture unit: circular pre/post-trigger history
// of pc/alu samples, ended by post count, timeout or PC stall.
module mips_trace_monitor
  import mips_trace_pkg::*;
#(
  parameter int PC_WIDTH       = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 16,
  parameter int POST_SAMPLES   = 8,
  parameter int TIMEOUT_CYCLES = 25,
  parameter int STALL_LIMIT    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PC_WIDTH-1:0]       pc_in,
  input  logic [DATA_WIDTH-1:0]     alu_in,
  input  logic                      arm,
  input  logic                      trig_en,
  input  logic [PC_WIDTH-1:0]       trig_pc,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic [PC_WIDTH-1:0]       rd_pc,
  output logic [DATA_WIDTH-1:0]     rd_alu,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic                      stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(POST_SAMPLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STALL_LIMIT);
  localparam int EW = PC_WIDTH + DATA_WIDTH;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] POST_TOP = PW'(POST_SAMPLES - 1);
  localparam logic [TW-1:0] TMO_TOP = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] REP_TOP = SW'(STALL_LIMIT - 2);
  localparam bit POST_ONE = (POST_SAMPLES == 1);

  trace_state_e state, state_n;

  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_q;
  logic [PW-1:0]       post_cnt;
  logic [TW-1:0]       cyc_cnt;
  logic [SW-1:0]       rep_cnt;
  logic [PC_WIDTH-1:0] prev_pc;
  logic                timeout_q, stall_q, rd_valid_q;

  logic start, wr, pop, trig;
  logic post_end, stall_hit, tmo_hit, same_pc;
  logic [EW-1:0] rd_data;

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    wr        = 1'b0;
    pop       = 1'b0;
    trig      = 1'b0;
    post_end  = 1'b0;
    stall_hit = 1'b0;
    tmo_hit   = 1'b0;
    same_pc   = (pc_in == prev_pc);
    unique case (state)
      IDLE: begin
        if (arm) begin
          start   = 1'b1;
          state_n = ARMED;
        end
      end
      ARMED: begin
        wr       = 1'b1;
        trig     = !trig_en || (pc_in == trig_pc);
        post_end = trig && POST_ONE;
        tmo_hit  = (cyc_cnt == TMO_TOP);
        if (trig) state_n = CAPTURE;
        if (post_end || tmo_hit) state_n = DONE;
      end
      CAPTURE: begin
        wr        = 1'b1;
        post_end  = (post_cnt == POST_TOP);
        stall_hit = same_pc && (rep_cnt == REP_TOP);
        tmo_hit   = (cyc_cnt == TMO_TOP);
        if (post_end || stall_hit || tmo_hit)
          state_n = DONE;
      end
      DONE: begin
        // arm outranks a same-cycle read
        if (arm) begin
          start   = 1'b1;
          state_n = ARMED;
        end else if (rd_en && count_q != '0) begin
          pop = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      post_cnt   <= '0;
      cyc_cnt    <= '0;
      rep_cnt    <= '0;
      prev_pc    <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (start) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count_q   <= '0;
        post_cnt  <= '0;
        cyc_cnt   <= '0;
        rep_cnt   <= '0;
        timeout_q <= 1'b0;
        stall_q   <= 1'b0;
      end
      if (wr) begin
        wr_ptr  <= wr_ptr + 1'b1;
        prev_pc <= pc_in;
        cyc_cnt <= cyc_cnt + 1'b1;
        // full buffer: drop the oldest entry
        if (count_q == FULL) rd_ptr <= rd_ptr + 1'b1;
        else                 count_q <= count_q + 1'b1;
        if (tmo_hit)   timeout_q <= 1'b1;
        if (stall_hit) stall_q   <= 1'b1;
      end
      if (trig) begin
        post_cnt <= PW'(1);
        rep_cnt  <= '0;
      end else if (state == CAPTURE) begin
        post_cnt <= post_cnt + 1'b1;
        rep_cnt  <= same_pc ? rep_cnt + 1'b1 : '0;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        count_q <= count_q - 1'b1;
      end
    end
  end

  mips_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr),
    .wr_addr (wr_ptr),
    .wr_data ({pc_in, alu_in}),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign rd_pc    = rd_data[EW-1:DATA_WIDTH];
  assign rd_alu   = rd_data[DATA_WIDTH-1:0];
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign busy     = (state == ARMED) || (state == CAPTURE);
  assign done     = (state == DONE);
  assign timeout  = timeout_q;
  assign stall    = stall_q;

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Bench for mips_trace_monitor: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_mips_trace_monitor;

  localparam int PW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int POST  = 8;
  localparam int TMO   = 25;
  localparam int SLIM  = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pc_in = '0;
  logic [DW-1:0] alu_in = '0;
  logic          arm = 1'b0;
  logic          trig_en = 1'b0;
  logic [PW-1:0] trig_pc = '0;
  logic          rd_en = 1'b0;
  logic          rd_valid;
  logic [PW-1:0] rd_pc;
  logic [DW-1:0] rd_alu;
  logic [CW-1:0] count;
  logic          busy, done, timeout, stall;

  mips_trace_monitor #(
    .PC_WIDTH       (PW),
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .POST_SAMPLES   (POST),
    .TIMEOUT_CYCLES (TMO),
    .STALL_LIMIT    (SLIM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_in    (pc_in),
    .alu_in   (alu_in),
    .arm      (arm),
    .trig_en  (trig_en),
    .trig_pc  (trig_pc),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_pc    (rd_pc),
    .rd_alu   (rd_alu),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: 0 idle, 1 armed, 2 capture, 3 done
  int          m_st;
  logic [31:0] m_q[$];
  int          m_post, m_rep, m_cyc;
  logic [15:0] m_prev;
  bit          m_tmo, m_stall, m_rv;
  logic [15:0] m_rpc, m_ralu;

  task automatic model_reset();
    m_st = 0;
    m_q.delete();
    m_post = 0;
    m_rep = 0;
    m_cyc = 0;
    m_prev = '0;
    m_tmo = 0;
    m_stall = 0;
    m_rv = 0;
    m_rpc = '0;
    m_ralu = '0;
  endtask

  task automatic model_step();
    m_rv = 0;
    if (arm && (m_st == 0 || m_st == 3)) begin
      m_q.delete();
      m_post = 0;
      m_rep = 0;
      m_cyc = 0;
      m_tmo = 0;
      m_stall = 0;
      m_st = 1;
    end else if (m_st == 1 || m_st == 2) begin
      bit fin;
      fin = 0;
      m_q.push_back({pc_in, alu_in});
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      m_cyc++;
      if (m_st == 1) begin
        if (!trig_en || pc_in == trig_pc) begin
          m_post = 1;
          m_rep = 0;
          m_st = 2;
        end
      end else begin
        m_post++;
        m_rep = (pc_in == m_prev) ? m_rep + 1 : 0;
        if (m_rep >= SLIM - 1) begin
          m_stall = 1;
          fin = 1;
        end
      end
      if (m_st == 2 && m_post >= POST) fin = 1;
      if (m_cyc >= TMO) begin
        m_tmo = 1;
        fin = 1;
      end
      m_prev = pc_in;
      if (fin) m_st = 3;
    end else if (m_st == 3 && rd_en && m_q.size() > 0) begin
      logic [31:0] e;
      e = m_q.pop_front();
      m_rv = 1;
      m_rpc = e[31:16];
      m_ralu = e[15:0];
    end
  endtask

  task automatic model_cmp();
    check("m_busy", busy, (m_st == 1 || m_st == 2));
    check("m_done", done, (m_st == 3));
    check("m_count", count, m_q.size());
    check("m_timeout", timeout, m_tmo);
    check("m_stall", stall, m_stall);
    check("m_rd_valid", rd_valid, m_rv);
    if (m_rv) begin
      check("m_rd_pc", rd_pc, m_rpc);
      check("m_rd_alu", rd_alu, m_ralu);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    model_cmp();
    alu_in = 16'($urandom);
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_pc"}, rd_pc, 0);
    check({tag, "_rd_alu"}, rd_alu, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_stall"}, stall, 0);
  endtask

  typedef struct {
    bit          a;
    bit          r;
    logic [15:0] pc;
    bit          e_busy;
    bit          e_done;
    bit          e_rv;
    int          e_cnt;
    logic [15:0] e_rpc;
  } vec_t;

  function automatic vec_t mk(bit a, bit r, int pc, bit b,
                              bit d, bit rv, int cnt, int rpc);
    vec_t v;
    v.a = a;
    v.r = r;
    v.pc = 16'(pc);
    v.e_busy = b;
    v.e_done = d;
    v.e_rv = rv;
    v.e_cnt = cnt;
    v.e_rpc = 16'(rpc);
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int pcs4[7];
    model_reset();

    // test 1 vectors: immediate trigger, 8 post samples, drain
    tbl.push_back(mk(1, 0, 100, 1, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, i, i < 7, i == 7, 0, i + 1, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 7 - k, k));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    trig_en = 1'b0;
    foreach (tbl[i]) begin
      arm = tbl[i].a;
      rd_en = tbl[i].r;
      pc_in = tbl[i].pc;
      cyc();
      check("t1_busy", busy, tbl[i].e_busy);
      check("t1_done", done, tbl[i].e_done);
      check("t1_count", count, tbl[i].e_cnt);
      check("t1_rd_valid", rd_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) check("t1_rd_pc", rd_pc, tbl[i].e_rpc);
    end
    arm = 0;
    rd_en = 0;

    // test 2: pre/post history around pc 20 with wrap
    trig_en = 1'b1;
    trig_pc = 16'd20;
    arm = 1;
    pc_in = 16'd5;
    cyc();
    arm = 0;
    pc_in = 16'd6;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (done) break;
      pc_in++;
    end
    check("t2_done", done, 1);
    check("t2_count", count, 16);
    check("t2_timeout", timeout, 0);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1;
      cyc();
      check("t2_rd_pc", rd_pc, 12 + i);
    end
    rd_en = 0;

    // test 3: trigger never fires -> timeout
    trig_pc = 16'd20;
    arm = 1;
    pc_in = 16'd0;
    cyc();
    arm = 0;
    for (int i = 0; i < TMO; i++) begin
      pc_in = 16'((i < 4) ? i : 3);
      cyc();
      if (i == TMO - 2) check("t3_busy", busy, 1);
    end
    check("t3_done", done, 1);
    check("t3_timeout", timeout, 1);
    check("t3_stall", stall, 0);
    check("t3_count", count, 16);

    // test 4: stall on the fourth repeated pc
    pcs4 = '{3, 4, 5, 6, 6, 6, 6};
    trig_pc = 16'd5;
    arm = 1;
    cyc();
    arm = 0;
    for (int i = 0; i < 7; i++) begin
      pc_in = 16'(pcs4[i]);
      cyc();
      if (i == 5) check("t4_stall_early", stall, 0);
    end
    check("t4_stall", stall, 1);
    check("t4_done", done, 1);
    check("t4_timeout", timeout, 0);
    check("t4_count", count, 7);
    for (int i = 0; i < 7; i++) begin
      rd_en = 1;
      cyc();
      check("t4_rd_pc", rd_pc, pcs4[i]);
    end
    rd_en = 0;

    // test 5: asynchronous reset mid-capture
    trig_en = 1'b0;
    arm = 1;
    cyc();
    arm = 0;
    for (int i = 0; i < 3; i++) begin
      pc_in = 16'(40 + i);
      cyc();
    end
    check("t5_pre_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    arm = 1;
    cyc();
    arm = 0;
    for (int i = 0; i < 8; i++) begin
      pc_in = 16'(50 + i);
      cyc();
    end
    check("t5_done", done, 1);
    check("t5_count", count, 8);

    // test 6: arm ignored while busy; arm beats rd_en in DONE
    arm = 1;
    cyc();
    arm = 0;
    for (int i = 0; i < 2; i++) begin
      pc_in = 16'(60 + i);
      cyc();
    end
    arm = 1;
    pc_in = 16'd62;
    cyc();
    arm = 0;
    check("t6_busy", busy, 1);
    check("t6_count", count, 3);
    for (int n = 0; n < 20; n++) begin
      pc_in++;
      cyc();
      if (done) break;
    end
    check("t6_done", done, 1);
    arm = 1;
    rd_en = 1;
    cyc();
    arm = 0;
    rd_en = 0;
    check("t6_rd_valid", rd_valid, 0);
    check("t6_count", count, 0);
    check("t6_busy_rearm", busy, 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      arm = ($urandom_range(0, 19) == 0);
      rd_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) trig_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) trig_pc = 16'($urandom_range(0, 15));
      r = $urandom_range(0, 3);
      if (r == 1 || r == 2) pc_in = pc_in + 1'b1;
      else if (r == 3) pc_in = 16'($urandom_range(0, 15));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
